store_packer: RTL and testbench

Store-side data path between the execute stage and the byte-addressable data memory. It is the write-direction counterpart of the load extractor:
- It accepts a store instruction, its effective address and rs2 data over a valid/ready handshake.
- It replicates the data across byte lanes, generates byte strobes and a word-aligned address, and issues the write to memory over a second valid/ready handshake.
- A two-entry buffer decouples the pipeline from memory stalls.
- It flags misaligned stores and counts completed writes.

---
 rtl/store_packer_if.sv | 35 +++
 rtl/store_packer.sv | 174 +++++++++++++++++
 tb/tb_store_packer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/store_packer_if.sv
// Bus bundle for store_packer: the request channel from execute and the
// write channel to data memory.
//
// Both channels use the same valid/ready rule. A transfer happens on a rising
// edge where valid && ready. The source holds valid and its payload stable
// until that transfer. Ready may change freely while valid is low.
interface store_packer_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_inst;
  logic [31:0] req_addr;
  logic [31:0] req_data;

  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;

  // Execute stage / memory model side.
  modport master (
    output req_valid, req_inst, req_addr, req_data,
    input  req_ready,
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready
  );

  // Packer side.
  modport slave (
    input  req_valid, req_inst, req_addr, req_data,
    output req_ready,
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready
  );
endinterface

// File: rtl/store_packer.sv
// Store data path: packs sb/sh/sw data into byte lanes with strobes, buffers
// up to two writes (output register + skid), flags misaligned stores.
module store_packer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  store_packer_if.slave    bus,
  output logic             misalign,
  output logic [31:0]      misalign_addr,
  output logic [CNT_W-1:0] store_count,
  output logic [1:0]       buf_state
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [2:0] F3_SB    = 3'b000;
  localparam logic [2:0] F3_SH    = 3'b001;
  localparam logic [2:0] F3_SW    = 3'b010;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        ready_q;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_store;
  logic        is_misal;
  logic        accept_any;
  logic        acc;
  logic        fire;

  logic [31:0] pk_addr;
  logic [31:0] pk_wdata;
  logic [3:0]  pk_wstrb;

  logic [31:0] out_addr;
  logic [31:0] out_wdata;
  logic [3:0]  out_wstrb;
  logic [31:0] skid_addr;
  logic [31:0] skid_wdata;
  logic [3:0]  skid_wstrb;

  logic        unused_inst;
  assign unused_inst = ^{bus.req_inst[31:15], bus.req_inst[11:7]};

  always_comb begin
    opcode   = bus.req_inst[6:0];
    funct3   = bus.req_inst[14:12];
    is_store = (opcode == OP_STORE) &&
               ((funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW));
    is_misal = ((funct3 == F3_SH) && bus.req_addr[0]) ||
               ((funct3 == F3_SW) && (bus.req_addr[1:0] != 2'b00));
  end

  // Illegal and misaligned requests still complete the handshake; only acc
  // allocates a buffer entry.
  assign accept_any = bus.req_valid && ready_q;
  assign acc        = accept_any && is_store && !is_misal;
  assign fire       = (state != ST_EMPTY) && bus.mem_ready;

  always_comb begin
    pk_addr  = {bus.req_addr[31:2], 2'b00};
    pk_wdata = bus.req_data;
    pk_wstrb = 4'b1111;
    case (funct3)
      F3_SB: begin
        pk_wdata = {4{bus.req_data[7:0]}};
        pk_wstrb = 4'b0001 << bus.req_addr[1:0];
      end
      F3_SH: begin
        pk_wdata = {2{bus.req_data[15:0]}};
        pk_wstrb = bus.req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        pk_wdata = bus.req_data;
        pk_wstrb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (acc) state_nxt = ST_ONE;
      ST_ONE: begin
        if (acc && !fire)      state_nxt = ST_TWO;
        else if (fire && !acc) state_nxt = ST_EMPTY;
        else                   state_nxt = ST_ONE;
      end
      ST_TWO:   if (fire) state_nxt = ST_ONE;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  // req_ready is registered from the next state, so TWO is never entered
  // with ready still high and no third entry is needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_EMPTY;
      ready_q <= 1'b1;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt != ST_TWO);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_addr   <= 32'd0;
      out_wdata  <= 32'd0;
      out_wstrb  <= 4'd0;
      skid_addr  <= 32'd0;
      skid_wdata <= 32'd0;
      skid_wstrb <= 4'd0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (acc) begin
            out_addr  <= pk_addr;
            out_wdata <= pk_wdata;
            out_wstrb <= pk_wstrb;
          end
        end
        ST_ONE: begin
          if (acc && fire) begin
            out_addr  <= pk_addr;
            out_wdata <= pk_wdata;
            out_wstrb <= pk_wstrb;
          end else if (acc) begin
            skid_addr  <= pk_addr;
            skid_wdata <= pk_wdata;
            skid_wstrb <= pk_wstrb;
          end
        end
        ST_TWO: begin
          if (fire) begin
            out_addr  <= skid_addr;
            out_wdata <= skid_wdata;
            out_wstrb <= skid_wstrb;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign      <= 1'b0;
      misalign_addr <= 32'd0;
    end else begin
      misalign <= accept_any && is_store && is_misal;
      if (accept_any && is_store && is_misal)
        misalign_addr <= bus.req_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       store_count <= '0;
    else if (fire) store_count <= store_count + CNT_W'(1);
  end

  assign bus.req_ready = ready_q;
  assign bus.mem_valid = (state != ST_EMPTY);
  assign bus.mem_addr  = out_addr;
  assign bus.mem_wdata = out_wdata;
  assign bus.mem_wstrb = out_wstrb;
  assign buf_state     = state;

endmodule

// File: tb/tb_store_packer.sv
// Bench for store_packer: table of single-store vectors plus hand-written
// stall, back-to-back, reset and counter-wrap sequences.
module tb_store_packer;
  localparam int CNT_W = 4;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_LD = 7'b0000011;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             misalign;
  logic [31:0]      misalign_addr;
  logic [CNT_W-1:0] store_count;
  logic [1:0]       buf_state;

  store_packer_if bus();

  store_packer #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .misalign      (misalign),
    .misalign_addr (misalign_addr),
    .store_count   (store_count),
    .buf_state     (buf_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
    logic [31:0] data;
    logic        vld;
    logic [31:0] maddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        mis;
  } vec_t;

  vec_t        vecs[11];
  int          total  = 0;
  int          passed = 0;
  int          fires  = 0;
  logic [67:0] exp_q[$];
  logic [31:0] exp_mis_addr;

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] op);
    return {17'd0, f3, 5'd0, op};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic send(input logic [31:0] inst, input logic [31:0] addr, input logic [31:0] data);
    bus.req_inst  = inst;
    bus.req_addr  = addr;
    bus.req_data  = data;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (bus.req_ready) begin
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    total++;
    $display("FAIL send_timeout: req_ready stayed 0 for addr %h", addr);
  endtask

  // Scoreboard: every write the memory takes must match the head of exp_q.
  always @(negedge clk) begin
    logic [67:0] e;
    if (!rst && bus.mem_valid && bus.mem_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_write: got addr %h expected no write", bus.mem_addr);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", bus.mem_addr, e[67:36]);
        check("wr_data", bus.mem_wdata, e[35:4]);
        check("wr_strb", {28'd0, bus.mem_wstrb}, {28'd0, e[3:0]});
      end
      fires++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_inst  = 32'd0;
    bus.req_addr  = 32'd0;
    bus.req_data  = 32'd0;
    bus.mem_ready = 1'b1;
    exp_mis_addr  = 32'd0;

    vecs[0]  = '{mk(3'b000, OP_ST), 32'h1003, 32'h000000A5, 1'b1, 32'h1000, 32'hA5A5A5A5, 4'b1000, 1'b0};
    vecs[1]  = '{mk(3'b001, OP_ST), 32'h2002, 32'h1234BEEF, 1'b1, 32'h2000, 32'hBEEFBEEF, 4'b1100, 1'b0};
    vecs[2]  = '{mk(3'b001, OP_ST), 32'h2001, 32'h1234BEEF, 1'b0, 32'h0,    32'h0,        4'b0000, 1'b1};
    vecs[3]  = '{mk(3'b010, OP_ST), 32'h3000, 32'hDEADBEEF, 1'b1, 32'h3000, 32'hDEADBEEF, 4'b1111, 1'b0};
    vecs[4]  = '{mk(3'b010, OP_ST), 32'h3002, 32'hDEADBEEF, 1'b0, 32'h0,    32'h0,        4'b0000, 1'b1};
    vecs[5]  = '{mk(3'b000, OP_ST), 32'h4000, 32'h12345678, 1'b1, 32'h4000, 32'h78787878, 4'b0001, 1'b0};
    vecs[6]  = '{mk(3'b000, OP_ST), 32'h4001, 32'h12345678, 1'b1, 32'h4000, 32'h78787878, 4'b0010, 1'b0};
    vecs[7]  = '{mk(3'b001, OP_ST), 32'h4000, 32'hCAFE0011, 1'b1, 32'h4000, 32'h00110011, 4'b0011, 1'b0};
    vecs[8]  = '{mk(3'b010, OP_LD), 32'h5000, 32'h55555555, 1'b0, 32'h0,    32'h0,        4'b0000, 1'b0};
    vecs[9]  = '{mk(3'b011, OP_ST), 32'h5000, 32'h66666666, 1'b0, 32'h0,    32'h0,        4'b0000, 1'b0};
    vecs[10] = '{mk(3'b011, OP_ST), 32'h5003, 32'h77777777, 1'b0, 32'h0,    32'h0,        4'b0000, 1'b0};

    // Reset values while rst is held.
    #2 rst = 1'b1;
    #1;
    check("rst_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_mem_wstrb", {28'd0, bus.mem_wstrb}, 32'd0);
    check("rst_misalign", {31'd0, misalign}, 32'd0);
    check("rst_misalign_addr", misalign_addr, 32'd0);
    check("rst_store_count", {28'd0, store_count}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single stores from EMPTY with memory always ready.
    for (int i = 0; i < 11; i++) begin
      send(vecs[i].inst, vecs[i].addr, vecs[i].data);
      check($sformatf("v%0d_valid", i), {31'd0, bus.mem_valid}, {31'd0, vecs[i].vld});
      check($sformatf("v%0d_ready", i), {31'd0, bus.req_ready}, 32'd1);
      if (vecs[i].vld) begin
        check($sformatf("v%0d_addr", i), bus.mem_addr, vecs[i].maddr);
        check($sformatf("v%0d_wdata", i), bus.mem_wdata, vecs[i].wdata);
        check($sformatf("v%0d_wstrb", i), {28'd0, bus.mem_wstrb}, {28'd0, vecs[i].wstrb});
        exp_q.push_back({vecs[i].maddr, vecs[i].wdata, vecs[i].wstrb});
      end
      check($sformatf("v%0d_misalign", i), {31'd0, misalign}, {31'd0, vecs[i].mis});
      if (vecs[i].mis) exp_mis_addr = vecs[i].addr;
      check($sformatf("v%0d_mis_addr", i), misalign_addr, exp_mis_addr);
      @(posedge clk); #1;
      check($sformatf("v%0d_idle", i), {31'd0, bus.mem_valid}, 32'd0);
      check($sformatf("v%0d_mis_pulse_end", i), {31'd0, misalign}, 32'd0);
      check($sformatf("v%0d_count", i), {28'd0, store_count}, 32'(fires % 16));
    end

    // Stall: three sw with memory not ready; only two fit.
    bus.mem_ready = 1'b0;
    exp_q.push_back({32'h0, 32'h11111111, 4'b1111});
    exp_q.push_back({32'h4, 32'h22222222, 4'b1111});
    send(mk(3'b010, OP_ST), 32'h0, 32'h11111111);
    send(mk(3'b010, OP_ST), 32'h4, 32'h22222222);
    check("stall_full_ready", {31'd0, bus.req_ready}, 32'd0);
    check("stall_full_state", {30'd0, buf_state}, 32'd2);
    fork
      send(mk(3'b010, OP_ST), 32'h8, 32'h33333333);
      begin
        for (int k = 0; k < 3; k++) begin
          @(posedge clk); #1;
          check("stall_hold_addr", bus.mem_addr, 32'h0);
          check("stall_hold_wdata", bus.mem_wdata, 32'h11111111);
          check("stall_hold_wstrb", {28'd0, bus.mem_wstrb}, 32'hF);
          check("stall_hold_ready", {31'd0, bus.req_ready}, 32'd0);
        end
        exp_q.push_back({32'h8, 32'h33333333, 4'b1111});
        bus.mem_ready = 1'b1;
      end
    join
    repeat (2) @(posedge clk);
    #1;
    check("stall_drained", 32'(exp_q.size()), 32'd0);
    check("stall_idle", {31'd0, bus.mem_valid}, 32'd0);
    check("stall_count", {28'd0, store_count}, 32'(fires % 16));

    // ONE with fire and accept together: output register takes the new store.
    exp_q.push_back({32'h100, 32'hAAAA0001, 4'b1111});
    exp_q.push_back({32'h104, 32'hAAAA0002, 4'b1111});
    exp_q.push_back({32'h108, 32'h000C000C, 4'b0011});
    send(mk(3'b010, OP_ST), 32'h100, 32'hAAAA0001);
    send(mk(3'b010, OP_ST), 32'h104, 32'hAAAA0002);
    check("b2b_addr1", bus.mem_addr, 32'h104);
    check("b2b_state1", {30'd0, buf_state}, 32'd1);
    check("b2b_ready1", {31'd0, bus.req_ready}, 32'd1);
    send(mk(3'b001, OP_ST), 32'h108, 32'hFFFF000C);
    check("b2b_addr2", bus.mem_addr, 32'h108);
    check("b2b_wdata2", bus.mem_wdata, 32'h000C000C);
    @(posedge clk); #1;
    check("b2b_drained", 32'(exp_q.size()), 32'd0);
    check("b2b_idle", {31'd0, bus.mem_valid}, 32'd0);

    // Reset with two buffered entries: discarded, outputs cleared at once.
    bus.mem_ready = 1'b0;
    send(mk(3'b010, OP_ST), 32'h200, 32'h12121212);
    send(mk(3'b010, OP_ST), 32'h204, 32'h34343434);
    check("pre_rst_state", {30'd0, buf_state}, 32'd2);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
    check("mid_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("mid_rst_mem_addr", bus.mem_addr, 32'd0);
    check("mid_rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("mid_rst_mem_wstrb", {28'd0, bus.mem_wstrb}, 32'd0);
    check("mid_rst_count", {28'd0, store_count}, 32'd0);
    check("mid_rst_state", {30'd0, buf_state}, 32'd0);
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    rst   = 1'b0;
    fires = 0;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_no_write", {31'd0, bus.mem_valid}, 32'd0);
    check("post_rst_count", {28'd0, store_count}, 32'd0);

    // Reset cancels a visible misalign pulse.
    send(mk(3'b001, OP_ST), 32'h2001, 32'h0);
    check("mis_before_rst", {31'd0, misalign}, 32'd1);
    check("mis_addr_before_rst", misalign_addr, 32'h2001);
    #2 rst = 1'b1;
    #1;
    check("mis_cancel", {31'd0, misalign}, 32'd0);
    check("mis_addr_cleared", misalign_addr, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Counter wrap with CNT_W=4: 17 writes leave store_count at 1.
    for (int k = 0; k < 17; k++) begin
      exp_q.push_back({32'h400 + 32'(4 * k), 32'(k), 4'b1111});
      send(mk(3'b010, OP_ST), 32'h400 + 32'(4 * k), 32'(k));
    end
    @(posedge clk); #1;
    check("wrap_count", {28'd0, store_count}, 32'd1);
    check("wrap_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
